// File: rtl/mem_stage_ctrl.sv
// Memory stage sequencer and MEM/WB pipeline register: drives a req/ack data memory,
// stalls upstream while an access is outstanding, and registers the writeback result.
module mem_stage_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       alu_out_m,
  input  logic [31:0]       write_data_m,
  input  logic [4:0]        dest_m,
  input  logic              mem_read_m,
  input  logic              mem_write_m,
  input  logic              reg_write_m,
  input  logic [1:0]        mem_to_reg_m,
  input  logic [5:0]        pc_plus1_m,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall_m,
  output logic [31:0]       result_wb,
  output logic [4:0]        dest_wb,
  output logic              reg_write_wb,
  output logic              mem_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         load_data_q, load_data_d;
  logic                abort_q, abort_d;
  logic                mem_err_q, mem_err_d;
  logic [31:0]         result_wb_q, result_wb_d;
  logic [4:0]          dest_wb_q, dest_wb_d;
  logic                reg_write_wb_q, reg_write_wb_d;
  logic                stall;
  logic                req;
  logic                mem_op;

  assign mem_op = mem_read_m | mem_write_m;

  // Access sequencer; the access attributes are captured on entry so they stay
  // stable for the whole REQ phase regardless of what EX/MEM shows.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    load_data_d = load_data_q;
    abort_d     = abort_q;
    mem_err_d   = mem_err_q;
    stall       = 1'b0;
    req         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          stall   = 1'b1;
          we_d    = mem_write_m;
          addr_d  = alu_out_m[ADDR_W-1:0];
          wdata_d = write_data_m;
          cnt_d   = '0;
          abort_d = 1'b0;
          if (mem_read_m && mem_write_m) begin
            mem_err_d = 1'b1;
          end
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        stall = 1'b1;
        req   = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem_ack) begin
          if (!we_q) begin
            load_data_d = dmem_rdata;
          end
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          mem_err_d   = 1'b1;
          load_data_d = '0;
          abort_d     = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        // EX/MEM advances at this edge, so IDLE sees the next instruction.
        cnt_d   = '0;
        abort_d = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // MEM/WB register: a stall inserts a bubble but keeps the last result visible.
  always_comb begin
    result_wb_d    = result_wb_q;
    dest_wb_d      = dest_wb_q;
    reg_write_wb_d = 1'b0;
    if (!stall) begin
      dest_wb_d = dest_m;
      case (mem_to_reg_m)
        2'b01:   result_wb_d = load_data_q;
        2'b10:   result_wb_d = {26'b0, pc_plus1_m};
        default: result_wb_d = alu_out_m;
      endcase
      reg_write_wb_d = reg_write_m & (dest_m != 5'd0) & ~abort_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      load_data_q    <= '0;
      abort_q        <= 1'b0;
      mem_err_q      <= 1'b0;
      result_wb_q    <= '0;
      dest_wb_q      <= '0;
      reg_write_wb_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      load_data_q    <= load_data_d;
      abort_q        <= abort_d;
      mem_err_q      <= mem_err_d;
      result_wb_q    <= result_wb_d;
      dest_wb_q      <= dest_wb_d;
      reg_write_wb_q <= reg_write_wb_d;
    end
  end

  assign dmem_req     = req;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign stall_m      = stall;
  assign result_wb    = result_wb_q;
  assign dest_wb      = dest_wb_q;
  assign reg_write_wb = reg_write_wb_q;
  assign mem_err      = mem_err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: expected writebacks and memory requests are
// queued by the stimulus and popped by independent monitors.
module tb_mem_stage_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] alu_out_m;
  logic [31:0] write_data_m;
  logic [4:0]  dest_m;
  logic        mem_read_m;
  logic        mem_write_m;
  logic        reg_write_m;
  logic [1:0]  mem_to_reg_m;
  logic [5:0]  pc_plus1_m;
  logic        dmem_req;
  logic        dmem_we;
  logic [7:0]  dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        stall_m;
  logic [31:0] result_wb;
  logic [4:0]  dest_wb;
  logic        reg_write_wb;
  logic        mem_err;

  mem_stage_ctrl #(.ADDR_W(8), .TIMEOUT(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_out_m    (alu_out_m),
    .write_data_m (write_data_m),
    .dest_m       (dest_m),
    .mem_read_m   (mem_read_m),
    .mem_write_m  (mem_write_m),
    .reg_write_m  (reg_write_m),
    .mem_to_reg_m (mem_to_reg_m),
    .pc_plus1_m   (pc_plus1_m),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_ack     (dmem_ack),
    .stall_m      (stall_m),
    .result_wb    (result_wb),
    .dest_wb      (dest_wb),
    .reg_write_wb (reg_write_wb),
    .mem_err      (mem_err)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  dest;
  } wb_t;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } mreq_t;

  wb_t   wb_q[$];
  mreq_t mem_q[$];

  int checks = 0;
  int errors = 0;
  int ack_delay = 0;
  int ack_cnt = 0;
  logic force_ack = 1'b0;
  int req_run = 0;
  int last_req_len = 0;
  logic prev_req = 1'b0;
  mreq_t cur_req;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Memory responder: ack in the ack_delay-th REQ cycle (0 = never).
  always @(negedge clk) begin
    if (dmem_req) begin
      ack_cnt  = ack_cnt + 1;
      dmem_ack = ((ack_delay != 0) && (ack_cnt == ack_delay)) || force_ack;
    end else begin
      ack_cnt  = 0;
      dmem_ack = force_ack;
    end
  end

  // Request monitor: new request is compared to the queue, then held for stability.
  always @(negedge clk) begin
    if (dmem_req && !prev_req) begin
      if (mem_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req actual=addr %h expected=none", dmem_addr);
      end else begin
        cur_req = mem_q.pop_front();
        chk("req_we", {31'b0, dmem_we}, {31'b0, cur_req.we});
        chk("req_addr", {24'b0, dmem_addr}, {24'b0, cur_req.addr});
        chk("req_wdata", dmem_wdata, cur_req.wdata);
      end
    end else if (dmem_req) begin
      chk("req_we_stable", {31'b0, dmem_we}, {31'b0, cur_req.we});
      chk("req_addr_stable", {24'b0, dmem_addr}, {24'b0, cur_req.addr});
      chk("req_wdata_stable", dmem_wdata, cur_req.wdata);
    end
    if (!dmem_req && prev_req) last_req_len = req_run;
    req_run  = dmem_req ? req_run + 1 : 0;
    prev_req = dmem_req;
  end

  // Writeback monitor: every reg_write_wb pulse must match a queued expectation.
  always @(negedge clk) begin
    wb_t e;
    if (reg_write_wb === 1'b1) begin
      if (wb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wb actual=%h/%0d expected=none", result_wb, dest_wb);
      end else begin
        e = wb_q.pop_front();
        chk("wb_result", result_wb, e.res);
        chk("wb_dest", {27'b0, dest_wb}, {27'b0, e.dest});
      end
    end
  end

  task automatic drive_nop();
    alu_out_m    = 32'hFFFF_FFFF;
    write_data_m = 32'h0;
    dest_m       = 5'd0;
    mem_read_m   = 1'b0;
    mem_write_m  = 1'b0;
    reg_write_m  = 1'b0;
    mem_to_reg_m = 2'b00;
    pc_plus1_m   = 6'd0;
  endtask

  // Called just after a rising edge; returns just after the edge that accepts it.
  task automatic issue(input string name, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] dest, input logic rd, input logic wr,
                       input logic rw, input logic [1:0] m2r, input logic [5:0] pc,
                       input int exp_stall);
    int   stalls;
    logic s;
    alu_out_m    = alu;
    write_data_m = wd;
    dest_m       = dest;
    mem_read_m   = rd;
    mem_write_m  = wr;
    reg_write_m  = rw;
    mem_to_reg_m = m2r;
    pc_plus1_m   = pc;
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      s = stall_m;
      if (s) stalls++;
      @(posedge clk);
      #1;
      if (!s) break;
    end
    drive_nop();
    chk({name, "_stall_cycles"}, stalls, exp_stall);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  initial begin
    wb_t   w;
    mreq_t m;
    reset      = 1'b0;
    dmem_rdata = 32'h0;
    dmem_ack   = 1'b0;
    drive_nop();
    repeat (2) @(negedge clk);
    chk("rst_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_stall", {31'b0, stall_m}, 32'd0);
    chk("rst_result", result_wb, 32'd0);
    chk("rst_dest", {27'b0, dest_wb}, 32'd0);
    chk("rst_regwr", {31'b0, reg_write_wb}, 32'd0);
    chk("rst_err", {31'b0, mem_err}, 32'd0);
    reset = 1'b1;
    sync();

    // ALU op passes in one cycle
    w = '{32'h1234_5678, 5'd5}; wb_q.push_back(w);
    issue("alu", 32'h1234_5678, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1, 2'b00, 6'd0, 0);

    // Load, ack in first REQ cycle; upper address bits are dropped
    ack_delay  = 1;
    dmem_rdata = 32'hDEAD_BEEF;
    m = '{1'b0, 8'h10, 32'h1111_1111}; mem_q.push_back(m);
    w = '{32'hDEAD_BEEF, 5'd7}; wb_q.push_back(w);
    issue("load", 32'h0000_0310, 32'h1111_1111, 5'd7, 1'b1, 1'b0, 1'b1, 2'b01, 6'd0, 2);
    chk("load_req_len", last_req_len, 1);

    // Store, ack after 4 REQ cycles; no register write
    ack_delay = 4;
    m = '{1'b1, 8'h44, 32'hA5A5_A5A5}; mem_q.push_back(m);
    issue("store", 32'h44, 32'hA5A5_A5A5, 5'd9, 1'b0, 1'b1, 1'b0, 2'b00, 6'd0, 5);
    chk("store_req_len", last_req_len, 4);
    chk("store_err", {31'b0, mem_err}, 32'd0);

    // Link writes pc+1
    w = '{32'h0000_002A, 5'd31}; wb_q.push_back(w);
    issue("link", 32'h0000_FFFF, 32'h0, 5'd31, 1'b0, 1'b0, 1'b1, 2'b10, 6'h2A, 0);

    // Destination 0 never writes
    issue("dest0", 32'h7777_7777, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 6'd0, 0);
    @(negedge clk);
    chk("dest0_regwr", {31'b0, reg_write_wb}, 32'd0);
    sync();

    // Select 11 behaves as ALU
    w = '{32'hCAFE_F00D, 5'd3}; wb_q.push_back(w);
    issue("sel11", 32'hCAFE_F00D, 32'h0, 5'd3, 1'b0, 1'b0, 1'b1, 2'b11, 6'h15, 0);

    // Timeout: load with no ack
    ack_delay = 0;
    m = '{1'b0, 8'h20, 32'h0}; mem_q.push_back(m);
    issue("timeout", 32'h20, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 2'b01, 6'd0, 17);
    @(negedge clk);
    chk("to_req_len", last_req_len, 16);
    chk("to_err", {31'b0, mem_err}, 32'd1);
    chk("to_result", result_wb, 32'd0);
    chk("to_regwr", {31'b0, reg_write_wb}, 32'd0);
    sync();

    w = '{32'h0BAD_CAFE, 5'd9}; wb_q.push_back(w);
    issue("after_to", 32'h0BAD_CAFE, 32'h0, 5'd9, 1'b0, 1'b0, 1'b1, 2'b00, 6'd0, 0);
    chk("err_sticky", {31'b0, mem_err}, 32'd1);

    // Reset in the second REQ cycle of an unacknowledged load
    m = '{1'b0, 8'h50, 32'h0}; mem_q.push_back(m);
    alu_out_m   = 32'h50;
    dest_m      = 5'd8;
    mem_read_m  = 1'b1;
    reg_write_m = 1'b1;
    mem_to_reg_m = 2'b01;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    drive_nop();
    #1;
    chk("mid_rst_req", {31'b0, dmem_req}, 32'd0);
    chk("mid_rst_stall", {31'b0, stall_m}, 32'd0);
    chk("mid_rst_regwr", {31'b0, reg_write_wb}, 32'd0);
    chk("mid_rst_err", {31'b0, mem_err}, 32'd0);
    @(negedge clk);
    force_ack = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("late_ack_req", {31'b0, dmem_req}, 32'd0);
    chk("late_ack_stall", {31'b0, stall_m}, 32'd0);
    @(negedge clk);
    chk("late_ack_req2", {31'b0, dmem_req}, 32'd0);
    force_ack = 1'b0;
    sync();

    // Read and write together: performed as a write, flags error
    ack_delay = 2;
    m = '{1'b1, 8'h33, 32'h0000_5555}; mem_q.push_back(m);
    w = '{32'h0000_0033, 5'd4}; wb_q.push_back(w);
    issue("conflict", 32'h33, 32'h0000_5555, 5'd4, 1'b1, 1'b1, 1'b1, 2'b00, 6'd0, 3);
    chk("conflict_err", {31'b0, mem_err}, 32'd1);

    repeat (3) @(negedge clk);
    chk("wb_queue_empty", wb_q.size(), 0);
    chk("mem_queue_empty", mem_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
